// File: rtl/debug_pkg.sv
// Shared constants and types for the debugger transmit path.
package debug_pkg;

  localparam logic [7:0] DBG_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } dbg_tx_state_t;

  function automatic int calc_nbytes(input int snap_w);
    return (snap_w + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_byte_sel.sv
// Combinational pick of byte i from the padded snapshot; byte 0 is the MSB byte.
module debug_byte_sel #(
  parameter int NBYTES = 256,
  parameter int BIDX_W = 9
) (
  input  logic [NBYTES*8-1:0] i_snap,
  input  logic [BIDX_W-1:0]   i_idx,
  output logic [7:0]          o_byte
);

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (i_idx == BIDX_W'(k)) o_byte = i_snap[(NBYTES-1-k)*8 +: 8];
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Captures a debug snapshot and streams it to the UART as a framed packet:
// sync, 16-bit length, payload window, XOR checksum over length and payload.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int SNAP_W = 2048,
  parameter int NBYTES = calc_nbytes(SNAP_W),
  parameter int BIDX_W = $clog2(NBYTES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send_signal,
  input  logic              mode_window,
  input  logic [BIDX_W-1:0] win_start,
  input  logic [BIDX_W-1:0] win_len,
  input  logic [SNAP_W-1:0] snap_data,
  input  logic              tx_busy,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              data_sent,
  output logic              overrun
);

  localparam int PAD_W = NBYTES * 8;
  localparam int LEN_W = 16;
  localparam logic [BIDX_W:0] NB_X = (BIDX_W+1)'(NBYTES);

  dbg_tx_state_t     r_state, w_next;
  logic [PAD_W-1:0]  r_snap;
  logic [BIDX_W-1:0] r_idx;
  logic [LEN_W-1:0]  r_len, r_rem;
  logic [7:0]        r_csum, r_last;
  logic              r_gap, r_overrun;

  logic              w_issue, w_accept, w_busy, w_start_ok;
  logic [7:0]        w_byte, w_payload;
  logic [BIDX_W:0]   w_avail, w_wlen;
  logic [BIDX_W-1:0] w_start;
  logic [LEN_W-1:0]  w_len;

  debug_byte_sel #(.NBYTES(NBYTES), .BIDX_W(BIDX_W)) u_sel (
    .i_snap (r_snap),
    .i_idx  (r_idx),
    .o_byte (w_payload)
  );

  // Payload range: window is clamped to the bytes that remain after its start.
  always_comb begin
    w_start_ok = ({1'b0, win_start} < NB_X);
    w_avail    = NB_X - {1'b0, win_start};
    w_wlen     = ({1'b0, win_len} < w_avail) ? {1'b0, win_len} : w_avail;
    if (mode_window) begin
      w_start = win_start;
      w_len   = w_start_ok ? LEN_W'(w_wlen) : '0;
    end else begin
      w_start = '0;
      w_len   = LEN_W'(NBYTES);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_byte  = r_last;
    unique case (r_state)
      ST_IDLE: if (send_signal) w_next = ST_SYNC;
      ST_SYNC: begin
        w_byte  = DBG_SYNC;
        w_issue = !tx_busy && !r_gap;
        if (w_issue) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        w_byte  = r_len[15:8];
        w_issue = !tx_busy && !r_gap;
        if (w_issue) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        w_byte  = r_len[7:0];
        w_issue = !tx_busy && !r_gap;
        if (w_issue) w_next = (r_len == '0) ? ST_CSUM : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_byte  = w_payload;
        w_issue = !tx_busy && !r_gap;
        if (w_issue && r_rem == LEN_W'(1)) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        w_byte  = r_csum;
        w_issue = !tx_busy && !r_gap;
        if (w_issue) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && send_signal;
  assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign wr_uart   = w_issue;
  assign w_data    = w_issue ? w_byte : r_last;
  assign busy      = w_busy;
  assign data_sent = (r_state == ST_DONE);
  assign overrun   = r_overrun;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // The gap flag hides the cycle before the UART reflects a write on tx_busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gap     <= 1'b0;
      r_overrun <= 1'b0;
      r_last    <= 8'h00;
    end else begin
      r_gap <= w_issue;
      if (send_signal && w_busy) r_overrun <= 1'b1;
      if (w_issue) r_last <= w_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_snap <= PAD_W'(snap_data);
      r_idx  <= w_start;
      r_len  <= w_len;
      r_rem  <= w_len;
      r_csum <= 8'h00;
    end else if (w_issue) begin
      case (r_state)
        ST_LEN_HI:  r_csum <= r_csum ^ r_len[15:8];
        ST_LEN_LO:  r_csum <= r_csum ^ r_len[7:0];
        ST_PAYLOAD: begin
          r_csum <= r_csum ^ w_payload;
          r_idx  <= r_idx + 1'b1;
          r_rem  <= r_rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed and randomized frames against a byte-list reference model.
module tb_debug_frame_tx;

  localparam int SW = 20, NB = 3, BW = 2;
  localparam int SWB = 2048, NBB = 256, BWB = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, send, mw, txb;
  logic [BW-1:0] ws, wl;
  logic [SW-1:0] snap;
  logic          wr, bsy, ds, ovr;
  logic [7:0]    wd;

  logic           rstb, sendb, mwb, txbb;
  logic [BWB-1:0] wsb, wlb;
  logic [SWB-1:0] snapb;
  logic           wrb, bsyb, dsb, ovrb;
  logic [7:0]     wdb;

  debug_frame_tx #(.SNAP_W(SW)) u_dut (
    .clock(clk), .reset(rst), .send_signal(send), .mode_window(mw),
    .win_start(ws), .win_len(wl), .snap_data(snap), .tx_busy(txb),
    .wr_uart(wr), .w_data(wd), .busy(bsy), .data_sent(ds), .overrun(ovr)
  );

  debug_frame_tx #(.SNAP_W(SWB)) u_big (
    .clock(clk), .reset(rstb), .send_signal(sendb), .mode_window(mwb),
    .win_start(wsb), .win_len(wlb), .snap_data(snapb), .tx_busy(txbb),
    .wr_uart(wrb), .w_data(wdb), .busy(bsyb), .data_sent(dsb), .overrun(ovrb)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$], gotb_q[$], exp_q[$];
  int got_cyc[$];
  int ds_cnt = 0, ds_cyc = 0, dsb_cnt = 0;

  always @(negedge clk) begin
    if (wr) begin got_q.push_back(wd); got_cyc.push_back(cyc); end
    if (ds) begin ds_cnt++; ds_cyc = cyc; end
    if (wrb) gotb_q.push_back(wdb);
    if (dsb) dsb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame from the byte-list view of the snapshot: byte i is the i-th byte from the top.
  function automatic void model(input logic [2047:0] s, input int nb, input bit win,
                                input int st, input int wln);
    int b0, l;
    logic [7:0] cs, b;
    b0 = win ? st : 0;
    if (!win) l = nb;
    else if (st >= nb) l = 0;
    else l = (wln < nb - st) ? wln : nb - st;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(l >> 8));
    exp_q.push_back(8'(l));
    cs = 8'(l >> 8) ^ 8'(l);
    for (int i = b0; i < b0 + l; i++) begin
      b = 8'(s >> (8 * (nb - 1 - i)));
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
  endfunction

  task automatic request(input bit win, input int st, input int wln,
                         input logic [SW-1:0] d, output int rc);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();
    send = 1'b1; mw = win; ws = BW'(st); wl = BW'(wln); snap = d;
    rc = cyc;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic wait_done(input int base, input bit rnd);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (ds_cnt != base) break;
      if (rnd) txb = 1'($urandom_range(0, 1));
    end
    txb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("data_sent_pulses", ds_cnt - base, 1);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (got_q.size() >= n) break;
    end
    check("wait_bytes", got_q.size() >= n, 1);
  endtask

  task automatic compare(input string tag, input logic [7:0] q[$], input int rc, input bit timing);
    check({tag, "_size"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), q[i], exp_q[i]);
    if (timing && got_cyc.size() == exp_q.size()) begin
      check({tag, "_first"}, got_cyc[0], rc + 1);
      for (int i = 1; i < got_cyc.size(); i++)
        check($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 2);
      check({tag, "_ds_cyc"}, ds_cyc, rc + 2 * exp_q.size());
    end
  endtask

  initial begin
    int rc, n0, base;
    logic [SW-1:0] d;
    bit win;
    int st, wln;

    rst = 1'b1; send = 1'b0; mw = 1'b0; ws = '0; wl = '0; snap = '0; txb = 1'b0;
    rstb = 1'b1; sendb = 1'b0; mwb = 1'b0; wsb = '0; wlb = '0; snapb = '0; txbb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wr", wr, 0);
    check("rst_wdata", wd, 8'h00);
    check("rst_busy", bsy, 0);
    check("rst_ds", ds, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0; rstb = 1'b0;

    // Full dump of the reference vector
    base = ds_cnt;
    request(1'b0, 0, 0, 20'hABCDE, rc);
    model(2048'(20'hABCDE), NB, 1'b0, 0, 0);
    wait_done(base, 1'b0);
    compare("full", got_q, rc, 1'b1);
    if (got_q.size() > 6) check("full_csum", got_q[6], 8'h6B);
    check("full_busy_after", bsy, 0);

    // Window cases: plain, clamped, start at end, zero length
    for (int k = 0; k < 4; k++) begin
      st  = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : 0;
      wln = (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 2 : 0;
      d = (k == 3) ? 20'(  $urandom) : 20'hABCDE;
      base = ds_cnt;
      request(1'b1, st, wln, d, rc);
      model(2048'(d), NB, 1'b1, st, wln);
      wait_done(base, 1'b0);
      compare($sformatf("win%0d", k), got_q, rc, 1'b1);
    end

    // Random frames with random UART back-pressure
    for (int k = 0; k < 6; k++) begin
      win = 1'($urandom_range(0, 1));
      st  = $urandom_range(0, 3);
      wln = $urandom_range(0, 3);
      d   = 20'($urandom);
      base = ds_cnt;
      request(win, st, wln, d, rc);
      model(2048'(d), NB, win, st, wln);
      wait_done(base, 1'b1);
      compare($sformatf("rnd%0d", k), got_q, rc, 1'b0);
    end

    // Long stall after LEN_HI while the live vector changes
    d = 20'h5A3C1;
    base = ds_cnt;
    request(1'b0, 0, 0, d, rc);
    model(2048'(d), NB, 1'b0, 0, 0);
    wait_bytes(2);
    txb = 1'b1;
    repeat (50) begin @(posedge clk); #1; snap = 20'($urandom); end
    #1;
    check("stall_no_strobe", got_q.size(), 2);
    check("stall_busy", bsy, 1);
    txb = 1'b0;
    wait_done(base, 1'b0);
    compare("stall", got_q, rc, 1'b0);

    // Request during a frame is ignored and latches overrun
    d = 20'h13579;
    base = ds_cnt;
    request(1'b0, 0, 0, d, rc);
    model(2048'(d), NB, 1'b0, 0, 0);
    wait_bytes(3);
    @(posedge clk); #1;
    send = 1'b1; mw = 1'b1; ws = 2'd2; wl = 2'd1; snap = 20'hFFFFF;
    @(posedge clk); #1;
    send = 1'b0; mw = 1'b0;
    wait_done(base, 1'b0);
    compare("ovr_frame", got_q, rc, 1'b1);
    check("ovr_set", ovr, 1);

    // Reset in the middle of the payload
    d = 20'h2468A;
    base = ds_cnt;
    request(1'b0, 0, 0, d, rc);
    wait_bytes(4);
    check("ovr_sticky", ovr, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = got_q.size();
    repeat (30) @(posedge clk);
    #2;
    check("rst_mid_strobes", got_q.size(), n0);
    check("rst_mid_ds", ds_cnt, base);
    check("rst_mid_busy", bsy, 0);
    check("rst_mid_ovr", ovr, 0);

    d = 20'hC0FFE;
    base = ds_cnt;
    request(1'b0, 0, 0, d, rc);
    model(2048'(d), NB, 1'b0, 0, 0);
    wait_done(base, 1'b0);
    compare("after_rst", got_q, rc, 1'b1);

    // Full 2048-bit snapshot on the wide instance
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) snapb[i*32 +: 32] = $urandom;
    gotb_q.delete();
    base = dsb_cnt;
    sendb = 1'b1;
    @(posedge clk); #1;
    sendb = 1'b0;
    model(snapb, NBB, 1'b0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (dsb_cnt != base) break;
    end
    check("big_done", dsb_cnt - base, 1);
    compare("big", gotb_q, 0, 1'b0);
    if (gotb_q.size() > 2) begin
      check("big_len_hi", gotb_q[1], 8'h01);
      check("big_len_lo", gotb_q[2], 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
